// File: rtl/adcsnap_capture_ctrl.sv
// ADC snapshot capture controller: arms on a start edge, waits for a trigger,
// then streams qualified samples into the snapshot BRAM and reports status.
module adcsnap_capture_ctrl #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
) (
   input  logic              user_clk,
   input  logic              user_rst_n,
   input  logic [31:0]       ctrl,
   input  logic              trig,
   input  logic [DATA_W-1:0] din,
   input  logic              din_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_data,
   output logic              bram_we,
   output logic [31:0]       status
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t              state_q;
   logic                start_prev_q;
   logic [ADDR_W:0]     count_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic                we_q;

   logic                start_edge_d;
   logic                wq_d;
   logic                tq_d;
   logic                last_wr_d;
   logic [ADDR_W:0]     count_inc_d;
   logic                unused_ctrl;

   assign start_edge_d = ctrl[0] & ~start_prev_q;
   assign wq_d         = ctrl[2] | din_we;
   assign tq_d         = ctrl[1] | trig;
   assign count_inc_d  = count_q + 1'b1;
   // Count only reaches 2^ADDR_W through the final write, so the low bits
   // being all ones identifies the write that fills the buffer.
   assign last_wr_d    = &count_q[ADDR_W-1:0];
   assign unused_ctrl  = ^ctrl[31:3];

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         state_q      <= ST_IDLE;
         start_prev_q <= 1'b0;
         count_q      <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         we_q         <= 1'b0;
      end else begin
         start_prev_q <= ctrl[0];
         we_q         <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_edge_d) begin
                  state_q <= ST_ARMED;
                  count_q <= '0;
               end
            end
            ST_ARMED: begin
               if (start_edge_d) begin
                  count_q <= '0;
               end else if (tq_d) begin
                  state_q <= ST_CAPTURE;
                  if (wq_d) begin
                     addr_q  <= count_q[ADDR_W-1:0];
                     data_q  <= din;
                     we_q    <= 1'b1;
                     count_q <= count_inc_d;
                     if (last_wr_d) state_q <= ST_DONE;
                  end
               end
            end
            ST_CAPTURE: begin
               // A re-arm wins over a sample arriving in the same cycle.
               if (start_edge_d) begin
                  state_q <= ST_ARMED;
                  count_q <= '0;
               end else if (wq_d) begin
                  addr_q  <= count_q[ADDR_W-1:0];
                  data_q  <= din;
                  we_q    <= 1'b1;
                  count_q <= count_inc_d;
                  if (last_wr_d) state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (start_edge_d) begin
                  state_q <= ST_ARMED;
                  count_q <= '0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bram_addr = addr_q;
   assign bram_data = data_q;
   assign bram_we   = we_q;

   always_comb begin
      status            = '0;
      status[31]        = (state_q == ST_DONE);
      status[30]        = (state_q == ST_ARMED);
      status[29]        = (state_q == ST_CAPTURE);
      status[ADDR_W:0]  = count_q;
   end

endmodule

// File: doc/adcsnap_capture_ctrl.md
# adcsnap_capture_ctrl

Capture controller for the ADC snapshot path. It arms on a software start bit and waits for a trigger. It then writes qualified ADC samples into the snapshot BRAM until the buffer is full. It also produces the 32-bit status word that the downstream software-readable status register (simulink2ppc) presents to the PowerPC as `user_data_in`.

## Interface
Parameters:
- ADDR_W, 11, BRAM address width; buffer depth is 2^ADDR_W words; legal range 2..28.
- DATA_W, 32, sample/BRAM data width.

Ports:
- user_clk  in  1  sole clock; all logic is rising-edge.
- user_rst_n  in  1  asynchronous, active-low reset; assertion is asynchronous, and deassertion is used synchronously to user_clk.
- ctrl  in  32  control word from the software control register, synchronous to user_clk. Bit0 start: a rising edge arms the controller. Bit1 trig_sel: 1 triggers immediately and ignores `trig`. Bit2 we_sel: 1 writes every cycle and ignores `din_we`. Other bits are ignored.
- trig  in  1  external trigger, level-sampled.
- din  in  DATA_W  ADC sample.
- din_we  in  1  sample-valid qualifier.
- bram_addr  out  ADDR_W  BRAM write address.
- bram_data  out  DATA_W  BRAM write data.
- bram_we  out  1  BRAM write enable.
- status  out  32  status word. Bit31 done. Bit30 armed. Bit29 capturing. Bits[ADDR_W:0] word count. All other bits are 0.

## Operation
- Edge detect: `start_prev` is a register holding ctrl[0]. start_edge = ctrl[0] & ~start_prev.
- Write qualifier: wq = ctrl[2] | din_we.
- Trigger: tq = ctrl[1] | trig.
- FSM states and transitions:
  - IDLE (reset state): on start_edge, go to ARMED and clear count.
  - ARMED:
    - If start_edge, stay in ARMED and clear count.
    - Else if tq, go to CAPTURE. The sample in the trigger cycle is written if wq is set in that cycle.
  - CAPTURE:
    - If start_edge, go to ARMED, clear count, and suppress the write in that cycle.
    - Else, if wq, write din at address count[ADDR_W-1:0] and increment count.
    - When the write that makes count = 2^ADDR_W occurs, go to DONE.
  - DONE: hold. On start_edge, go to ARMED, clear count and clear done.
- Count: ADDR_W+1 bits, unsigned.
  - Never exceeds 2^ADDR_W.
  - The address never wraps, so no write occurs after the buffer is full.
- Status bits:
  - done = (state == DONE).
  - armed = (state == ARMED).
  - capturing = (state == CAPTURE).
- Start held high causes no re-arm; only a 0→1 transition arms.
- A trigger while in IDLE or DONE is ignored.
- din_we while not in ARMED or CAPTURE is ignored.

## Timing
- All outputs are registered.
- Reset values: bram_addr=0, bram_data=0, bram_we=0, status=0x00000000; state=IDLE; start_prev=0; count=0.
- Arm latency: start_edge in cycle t → status.armed=1 in cycle t+1.
- Write latency: a sample qualified in cycle t (trigger cycle or capture cycle) → bram_we=1, bram_addr=n and bram_data=din(t) in cycle t+1.
  - n is the count value in cycle t.
  - status.count = n+1 in the same cycle t+1.
- Completion: the cycle that presents the final write (addr 2^ADDR_W-1) also shows status.done=1, capturing=0 and count=2^ADDR_W.
- Re-arm during capture: start_edge in cycle t → bram_we=0 and count=0 in cycle t+1, with armed=1.
- bram_we is a single-cycle pulse per qualified sample.
- There is no backpressure; the BRAM accepts one write per cycle.
- Reset mid-capture: all outputs return to reset values asynchronously. No partial write is emitted after reset release.

## Test plan
- Reset/idle (ADDR_W=4):
  - Apply reset, then drive trig=1, din_we=1, ctrl=0 for 20 cycles.
  - Required: bram_we never asserts and status stays 0x00000000.
- Immediate full capture:
  - Pulse ctrl=0x7 after ctrl=0, with din incrementing from 0xA0.
  - Required: 16 consecutive bram_we pulses with addr 0..15 and data 0xA0..0xAF.
  - Required: on the last write cycle, status=0x80000010; it holds until the next start edge.
- Gated external trigger:
  - Set ctrl=0x1 (0→1 edge) and keep trig=0 for 10 cycles.
  - Required: status=0x40000000.
  - Then set trig=1 for one cycle with din_we toggling 1,0,1,0.
  - Required: writes occur only for din_we=1 samples, at consecutive addresses starting at 0, and the trigger-cycle sample is at addr 0.
- Re-arm mid-capture:
  - After 5 writes, drop ctrl[0] for one cycle and raise it again while wq=1.
  - Required: no write in the edge response cycle, status=0x40000000, and the next capture restarts at addr 0.
- Start held high:
  - After DONE, keep ctrl[0]=1 for 50 cycles.
  - Required: status stays 0x80000010 and no writes occur.
  - Then toggle ctrl[0] 0→1.
  - Required: armed=1, done=0, count=0.
- Async reset mid-capture:
  - Assert user_rst_n=0 between clock edges at count=7.
  - Required: outputs go to 0 before the next edge, and the state is IDLE after release.
